// File: rtl/wb_commit_if.sv
// Producer/register-file bundle for the writeback commit unit.
// slave = commit unit side, master = producers, register file and decode.
interface wb_commit_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic                     alu_valid;
   logic                     alu_ready;
   logic [ADDR_W-1:0]        alu_dst;
   logic [DATA_W-1:0]        alu_data;
   logic                     mem_valid;
   logic                     mem_ready;
   logic [ADDR_W-1:0]        mem_dst;
   logic [DATA_W-1:0]        mem_data;
   logic                     rf_write;
   logic [ADDR_W-1:0]        rf_dst;
   logic [DATA_W-1:0]        rf_data;
   logic [ADDR_W-1:0]        rs_a;
   logic [ADDR_W-1:0]        rt_a;
   logic                     rs_pending;
   logic                     rt_pending;
   logic [$clog2(DEPTH):0]   count;
   logic                     full;
   logic                     empty;

   modport slave (
      input  alu_valid, alu_dst, alu_data,
      input  mem_valid, mem_dst, mem_data,
      input  rs_a, rt_a,
      output alu_ready, mem_ready,
      output rf_write, rf_dst, rf_data,
      output rs_pending, rt_pending,
      output count, full, empty
   );

   modport master (
      output alu_valid, alu_dst, alu_data,
      output mem_valid, mem_dst, mem_data,
      output rs_a, rt_a,
      input  alu_ready, mem_ready,
      input  rf_write, rf_dst, rf_data,
      input  rs_pending, rt_pending,
      input  count, full, empty
   );
endinterface

// File: rtl/wb_commit.sv
// Writeback commit unit: in-order result FIFO draining one register-file write per cycle.
// Define WB_BYPASS_EN to let an accepted result skip an empty FIFO and commit in the same cycle.
module wb_commit #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic       clk,
   input  logic       reset,
   wb_commit_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] dst_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              full_s, empty_s;
   logic              mem_acc_s, alu_acc_s, acc_s;
   logic              push_s, pop_s, byp_s;
   logic [ADDR_W-1:0] in_dst_s;
   logic [DATA_W-1:0] in_data_s;
   logic              rs_hit_s, rt_hit_s;

   // Handshake arbitration (loads win), push/pop decision and next-state.
   always_comb begin
      full_s    = (count_q == CNT_W'(DEPTH));
      empty_s   = (count_q == CNT_W'(0));
      mem_acc_s = bus.mem_valid && !full_s;
      alu_acc_s = bus.alu_valid && !full_s && !bus.mem_valid;
      acc_s     = mem_acc_s || alu_acc_s;
      if (mem_acc_s) begin
         in_dst_s  = bus.mem_dst;
         in_data_s = bus.mem_data;
      end else begin
         in_dst_s  = bus.alu_dst;
         in_data_s = bus.alu_data;
      end
`ifdef WB_BYPASS_EN
      byp_s = acc_s && empty_s && (in_dst_s != ADDR_W'(0));
`else
      byp_s = 1'b0;
`endif
      // r0 writes complete the handshake but never occupy a slot
      push_s = acc_s && (in_dst_s != ADDR_W'(0)) && !byp_s;
      pop_s  = !empty_s;

      wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

      vld_d = vld_q;
      if (pop_s) begin
         vld_d[rd_ptr_q] = 1'b0;
      end else begin
         vld_d = vld_d;
      end
      if (push_s) begin
         vld_d[wr_ptr_q] = 1'b1;
      end else begin
         vld_d = vld_d;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer, occupancy and valid-bit registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         count_q  <= CNT_W'(0);
         vld_q    <= {DEPTH{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         vld_q    <= vld_d;
      end
   end

   // Entry payload storage written at the tail.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            dst_q[i]  <= ADDR_W'(0);
            data_q[i] <= DATA_W'(0);
         end
      end else if (push_s) begin
         dst_q[wr_ptr_q]  <= in_dst_s;
         data_q[wr_ptr_q] <= in_data_s;
      end
   end

   // Register-file port, hazard lookup and status outputs.
   always_comb begin
      bus.mem_ready = !full_s;
      bus.alu_ready = !full_s && !bus.mem_valid;
      bus.count     = count_q;
      bus.full      = full_s;
      bus.empty     = empty_s;

      if (!empty_s) begin
         bus.rf_write = 1'b1;
         bus.rf_dst   = dst_q[rd_ptr_q];
         bus.rf_data  = data_q[rd_ptr_q];
      end else if (byp_s) begin
         bus.rf_write = 1'b1;
         bus.rf_dst   = in_dst_s;
         bus.rf_data  = in_data_s;
      end else begin
         bus.rf_write = 1'b0;
         bus.rf_dst   = ADDR_W'(0);
         bus.rf_data  = DATA_W'(0);
      end

      rs_hit_s = 1'b0;
      rt_hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (dst_q[i] == bus.rs_a)) begin
            rs_hit_s = 1'b1;
         end else begin
            rs_hit_s = rs_hit_s;
         end
         if (vld_q[i] && (dst_q[i] == bus.rt_a)) begin
            rt_hit_s = 1'b1;
         end else begin
            rt_hit_s = rt_hit_s;
         end
      end
      bus.rs_pending = rs_hit_s && (bus.rs_a != ADDR_W'(0));
      bus.rt_pending = rt_hit_s && (bus.rt_a != ADDR_W'(0));
   end
endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations and a randomized producer phase.
module tb_wb_commit;
   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [ADDR_W-1:0] dst;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   ent_t mq[$];
   ent_t wlog[$];
   bit   m_alu_acc = 1'b0;
   bit   m_mem_acc = 1'b0;

   wb_commit_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   wb_commit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a plain queue of committed-but-not-written results.
   always @(posedge clk or negedge reset) begin
      bit   was_full, was_empty;
      ent_t e;
      if (!reset) begin
         mq.delete();
         m_alu_acc = 1'b0;
         m_mem_acc = 1'b0;
      end else begin
         was_full  = (mq.size() == DEPTH);
         was_empty = (mq.size() == 0);
         m_mem_acc = bus.mem_valid && !was_full;
         m_alu_acc = bus.alu_valid && !was_full && !bus.mem_valid;
         e = m_mem_acc ? {bus.mem_dst, bus.mem_data} : {bus.alu_dst, bus.alu_data};
         if (!was_empty) void'(mq.pop_front());
         if ((m_mem_acc || m_alu_acc) && e.dst != 0 && !(BYP && was_empty))
            mq.push_back(e);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      bit                full_m, empty_m, acc_m, byp_m, w_m, rsp_m, rtp_m;
      ent_t              e;
      logic [ADDR_W-1:0] d_m;
      logic [DATA_W-1:0] dt_m;
      full_m  = (mq.size() == DEPTH);
      empty_m = (mq.size() == 0);
      acc_m   = !full_m && (bus.mem_valid || bus.alu_valid);
      e       = bus.mem_valid ? {bus.mem_dst, bus.mem_data} : {bus.alu_dst, bus.alu_data};
      byp_m   = BYP && empty_m && acc_m && (e.dst != 0);
      if (!empty_m) begin
         w_m = 1'b1; d_m = mq[0].dst; dt_m = mq[0].data;
      end else if (byp_m) begin
         w_m = 1'b1; d_m = e.dst; dt_m = e.data;
      end else begin
         w_m = 1'b0; d_m = '0; dt_m = '0;
      end
      rsp_m = 1'b0;
      rtp_m = 1'b0;
      foreach (mq[i]) begin
         if (mq[i].dst == bus.rs_a) rsp_m = 1'b1;
         if (mq[i].dst == bus.rt_a) rtp_m = 1'b1;
      end
      rsp_m = rsp_m && (bus.rs_a != 0);
      rtp_m = rtp_m && (bus.rt_a != 0);

      chk("mem_ready",  bus.mem_ready,  !full_m);
      chk("alu_ready",  bus.alu_ready,  !full_m && !bus.mem_valid);
      chk("rf_write",   bus.rf_write,   w_m);
      chk("rf_dst",     bus.rf_dst,     d_m);
      chk("rf_data",    bus.rf_data,    dt_m);
      chk("rs_pending", bus.rs_pending, rsp_m);
      chk("rt_pending", bus.rt_pending, rtp_m);
      chk("count",      bus.count,      mq.size());
      chk("full",       bus.full,       full_m);
      chk("empty",      bus.empty,      empty_m);
      if (bus.rf_write === 1'b1) wlog.push_back({bus.rf_dst, bus.rf_data});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle();
      bus.alu_valid = 1'b0; bus.alu_dst = '0; bus.alu_data = '0;
      bus.mem_valid = 1'b0; bus.mem_dst = '0; bus.mem_data = '0;
   endtask

   initial begin
      idle();
      bus.rs_a = '0;
      bus.rt_a = '0;

      // Reset for two cycles, then release.
      tick(); tick();
      reset = 1'b1;
      settle();
      chk("rst_rf_write",  bus.rf_write,  1'b0);
      chk("rst_count",     bus.count,     0);
      chk("rst_empty",     bus.empty,     1'b1);
      chk("rst_full",      bus.full,      1'b0);
      chk("rst_alu_ready", bus.alu_ready, 1'b1);
      chk("rst_mem_ready", bus.mem_ready, 1'b1);

      // Single ALU write to r5.
      tick();
      bus.alu_valid = 1'b1; bus.alu_dst = 5'd5; bus.alu_data = 32'h0000_00AA;
      settle();
      chk("r5_accept_ready", bus.alu_ready, 1'b1);
      chk("r5_accept_write", bus.rf_write,  BYP);
      tick();
      idle();
      settle();
      chk("r5_next_write", bus.rf_write, !BYP);
      chk("r5_next_dst",   bus.rf_dst,   BYP ? 5'd0 : 5'd5);
      chk("r5_next_data",  bus.rf_data,  BYP ? 32'h0 : 32'h0000_00AA);
      tick();
      settle();
      chk("r5_after_write", bus.rf_write, 1'b0);

      // Simultaneous producers: load wins, ALU held one cycle.
      tick();
      wlog.delete();
      bus.alu_valid = 1'b1; bus.alu_dst = 5'd3; bus.alu_data = 32'h11;
      bus.mem_valid = 1'b1; bus.mem_dst = 5'd4; bus.mem_data = 32'h22;
      settle();
      chk("prio_mem_ready", bus.mem_ready, 1'b1);
      chk("prio_alu_ready", bus.alu_ready, 1'b0);
      tick();
      bus.mem_valid = 1'b0; bus.mem_dst = '0; bus.mem_data = '0;
      settle();
      chk("prio_alu_ready2", bus.alu_ready, 1'b1);
      tick();
      idle();
      tick(); tick();
      chk("order_len",   wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("order_first",  wlog[0], {5'd4, 32'h22});
         chk("order_second", wlog[1], {5'd3, 32'h11});
      end

      // Back-to-back pushes r1..r4 with decode watching r2 and r0.
      bus.rs_a = 5'd2;
      bus.rt_a = 5'd0;
      for (int k = 1; k <= 4; k++) begin
         bus.alu_valid = 1'b1; bus.alu_dst = ADDR_W'(k); bus.alu_data = DATA_W'(k * 16);
         settle();
         chk("fill_count_le_depth", bus.count <= DEPTH, 1'b1);
         chk("fill_rt0_pending",    bus.rt_pending, 1'b0);
         chk("fill_rs2_pending",    bus.rs_pending, !BYP && (k == 3));
         tick();
      end
      idle();
      settle();
      chk("fill_rs2_tail",    bus.rs_pending, 1'b0);
      tick(); tick();

      // Write to r0 is swallowed.
      bus.alu_valid = 1'b1; bus.alu_dst = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
      settle();
      chk("r0_ready", bus.alu_ready, 1'b1);
      chk("r0_write", bus.rf_write,  1'b0);
      tick();
      idle();
      settle();
      chk("r0_count", bus.count,    0);
      chk("r0_write2", bus.rf_write, 1'b0);
      tick();

      // Queue three results then reset mid-drain.
      for (int k = 0; k < 3; k++) begin
         bus.alu_valid = 1'b1; bus.alu_dst = ADDR_W'(7 + k); bus.alu_data = DATA_W'(32'hC0DE_0000 + k);
         tick();
      end
      idle();
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_write", bus.rf_write, 1'b0);
      chk("mid_rst_count", bus.count,    0);
      chk("mid_rst_empty", bus.empty,    1'b1);
      tick();
      reset = 1'b1;
      settle();
      chk("post_rst_ready", bus.alu_ready, 1'b1);
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("post_rst_no_write", bus.rf_write, 1'b0);
         tick();
      end

      // Randomized producers honouring valid/ready hold rules.
      for (int c = 0; c < 3000; c++) begin
         if (bus.alu_valid && m_alu_acc) bus.alu_valid = 1'b0;
         if (bus.mem_valid && m_mem_acc) bus.mem_valid = 1'b0;
         if (!bus.alu_valid && $urandom_range(0, 2) != 0) begin
            bus.alu_valid = 1'b1;
            bus.alu_dst   = ADDR_W'($urandom_range(0, 7));
            bus.alu_data  = $urandom;
         end
         if (!bus.mem_valid && $urandom_range(0, 2) == 0) begin
            bus.mem_valid = 1'b1;
            bus.mem_dst   = ADDR_W'($urandom_range(0, 7));
            bus.mem_data  = $urandom;
         end
         bus.rs_a = ADDR_W'($urandom_range(0, 7));
         bus.rt_a = ADDR_W'($urandom_range(0, 7));
         tick();
      end
      idle();
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
